decode_mul_pipe: RTL and testbench

Parametrised pipelined multiplier for the decode datapath. It multiplies two operands with per-transaction signedness selection, then rounds, shifts and saturates the product to the output width. A valid/ready handshake with per-stage bubble collapse lets it sit directly between streaming stages that can stall. It is the general replacement for the fixed-width, always-enabled, single-register multiply blocks.

---
 rtl/decode_mul_pipe.sv | 118 +++++++++++
 tb/tb_decode_mul_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, round-half-up, arithmetic shift and
// saturation to a signed output; valid/ready handshake with per-stage bubble collapse.
module decode_mul_pipe #(
    parameter int unsigned din0_WIDTH = 40,
    parameter int unsigned din1_WIDTH = 21,
    parameter int unsigned dout_WIDTH = 32,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned SHIFT      = 28,
    parameter int unsigned ROUND      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic                  din0_signed,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din1_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int unsigned P   = din0_WIDTH + din1_WIDTH + 2;
    localparam int unsigned R   = P + 1;
    localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam int unsigned HW  = R - dout_WIDTH + 1;
    localparam logic signed [R-1:0] RND = (ROUND != 0 && SHIFT > 0) ? (R'(1) << RSH) : '0;

    logic signed [P-1:0]   a_ext;
    logic signed [P-1:0]   b_ext;
    logic signed [P-1:0]   prod;
    logic signed [R-1:0]   rounded;
    logic signed [R-1:0]   shifted;
    logic [HW-1:0]         hi;
    logic                  sat;
    logic [dout_WIDTH-1:0] res;

    // One extra bit per operand lets unsigned inputs ride a signed multiply; P bits hold the exact product.
    assign a_ext   = {{(P - din0_WIDTH){din0_signed & din0[din0_WIDTH-1]}}, din0};
    assign b_ext   = {{(P - din1_WIDTH){din1_signed & din1[din1_WIDTH-1]}}, din1};
    assign prod    = a_ext * b_ext;
    assign rounded = {prod[P-1], prod} + RND;
    assign shifted = rounded >>> SHIFT;

    // Result fits only if every bit above the output sign bit repeats the sign.
    assign hi  = shifted[R-1:dout_WIDTH-1];
    assign sat = ~((&hi) | ~(|hi));

    always_comb begin
        res = shifted[dout_WIDTH-1:0];
        if (sat) begin
            res = shifted[R-1] ? {1'b1, {(dout_WIDTH - 1){1'b0}}} : {1'b0, {(dout_WIDTH - 1){1'b1}}};
        end
    end

    logic [NUM_STAGE-1:0]  vld;
    logic [NUM_STAGE-1:0]  load;
    logic [NUM_STAGE-1:0]  src_vld;
    logic [NUM_STAGE-1:0]  ovf_q;
    logic [NUM_STAGE-1:0]  src_ovf;
    logic [dout_WIDTH-1:0] data_q   [NUM_STAGE];
    logic [dout_WIDTH-1:0] src_data [NUM_STAGE];
    logic                  chain;

    // A stage may load if the output drains or any stage at or below it is empty.
    always_comb begin
        load  = '0;
        chain = out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            chain   = chain | ~vld[k];
            load[k] = chain;
        end
    end

    assign in_ready = reset & load[0];

    always_comb begin
        src_vld = '0;
        src_ovf = '0;
        for (int k = 0; k < NUM_STAGE; k++) begin
            src_data[k] = '0;
        end
        src_vld[0]  = in_valid & in_ready;
        src_data[0] = res;
        src_ovf[0]  = sat;
        for (int k = 1; k < NUM_STAGE; k++) begin
            src_vld[k]  = vld[k-1];
            src_data[k] = data_q[k-1];
            src_ovf[k]  = ovf_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld   <= '0;
            ovf_q <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGE; k++) begin
                if (load[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        data_q[k] <= src_data[k];
                        ovf_q[k]  <= src_ovf[k];
                    end
                end
            end
        end
    end

    assign out_valid = vld[NUM_STAGE-1];
    assign dout      = data_q[NUM_STAGE-1];
    assign ovf       = ovf_q[NUM_STAGE-1];

endmodule

// File: tb/tb_decode_mul_pipe.sv
// Bench for decode_mul_pipe: directed vectors on the default block, scoreboards on
// depth 1/3/6 and truncating variants sharing the same stimulus.
module tb_decode_mul_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        din0_signed;
    logic        din1_signed;
    logic [39:0] din0;
    logic [20:0] din1;
    logic [3:0]  rdy;
    logic [3:0]  ovalid;
    logic [3:0]  ovf_o;
    logic [31:0] dout_o [4];
    logic [32:0] sbq [4][$];

    int          vectors = 0;
    int          miscompares = 0;
    int          nacc;
    int          stall_left;
    int          qs;
    bit          acc;
    bit          seen;
    logic [31:0] held;

    always #5 clk = ~clk;

    decode_mul_pipe #(.NUM_STAGE(3), .ROUND(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .din0(din0), .din0_signed(din0_signed), .din1(din1), .din1_signed(din1_signed),
        .out_valid(ovalid[0]), .out_ready(out_ready), .dout(dout_o[0]), .ovf(ovf_o[0]));
    decode_mul_pipe #(.NUM_STAGE(3), .ROUND(0)) u_r0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .din0(din0), .din0_signed(din0_signed), .din1(din1), .din1_signed(din1_signed),
        .out_valid(ovalid[1]), .out_ready(out_ready), .dout(dout_o[1]), .ovf(ovf_o[1]));
    decode_mul_pipe #(.NUM_STAGE(1), .ROUND(1)) u_n1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .din0(din0), .din0_signed(din0_signed), .din1(din1), .din1_signed(din1_signed),
        .out_valid(ovalid[2]), .out_ready(out_ready), .dout(dout_o[2]), .ovf(ovf_o[2]));
    decode_mul_pipe #(.NUM_STAGE(6), .ROUND(1)) u_n6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]),
        .din0(din0), .din0_signed(din0_signed), .din1(din1), .din1_signed(din1_signed),
        .out_valid(ovalid[3]), .out_ready(out_ready), .dout(dout_o[3]), .ovf(ovf_o[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact 128-bit arithmetic, then compare against the signed output range.
    function automatic logic [32:0] model(input logic [39:0] a, input logic sa,
                                          input logic [20:0] b, input logic sb, input bit rnd);
        logic signed [127:0] x;
        logic signed [127:0] y;
        logic signed [127:0] p;
        x = {{88{sa & a[39]}}, a};
        y = {{107{sb & b[20]}}, b};
        p = x * y;
        if (rnd) p = p + (128'sd1 <<< 27);
        p = p >>> 28;
        if (p > 128'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (p < -128'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, p[31:0]};
    endfunction

    // Per-instance scoreboards: push on accept, pop and compare on release.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (ovalid[i] && out_ready) begin
                    chk($sformatf("sb%0d_has_entry", i), 64'(sbq[i].size() != 0), 64'(1));
                    if (sbq[i].size() != 0) begin
                        chk($sformatf("sb%0d_result", i), 64'({ovf_o[i], dout_o[i]}),
                            64'(sbq[i].pop_front()));
                    end
                end
                if (in_valid && rdy[i]) begin
                    sbq[i].push_back(model(din0, din0_signed, din1, din1_signed, i != 1));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [39:0] a, input logic sa, input logic [20:0] b, input logic sb);
        din0        = a;
        din0_signed = sa;
        din1        = b;
        din1_signed = sb;
    endtask

    task automatic rand_op();
        int unsigned mode;
        mode        = $urandom_range(0, 2);
        din0_signed = 1'($urandom_range(0, 1));
        din1_signed = 1'($urandom_range(0, 1));
        case (mode)
            0: begin
                din0 = 40'({$urandom, $urandom});
                din1 = 21'($urandom);
            end
            1: begin
                din0 = 40'(longint'(int'($urandom)));
                din1 = 21'($urandom_range(0, 4095));
            end
            default: begin
                din0 = 40'($urandom_range(0, 1000));
                din1 = 21'($urandom);
            end
        endcase
    endtask

    // Single op through an empty pipe; checks default and truncating results at latency 3.
    task automatic op_check(input string tag, input logic [39:0] a, input logic sa,
                            input logic [20:0] b, input logic sb,
                            input logic [31:0] e_rnd, input logic [31:0] e_trunc, input logic e_ovf);
        set_op(a, sa, b, sb);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, 64'(ovalid[0]), 64'(1));
        chk({tag, "_dout"}, 64'(dout_o[0]), 64'(e_rnd));
        chk({tag, "_ovf"}, 64'(ovf_o[0]), 64'(e_ovf));
        chk({tag, "_dout_trunc"}, 64'(dout_o[1]), 64'(e_trunc));
        chk({tag, "_ovf_trunc"}, 64'(ovf_o[1]), 64'(e_ovf));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op(40'h0, 1'b0, 21'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ovalid[0]), 64'(0));
        chk("rst_dout", 64'(dout_o[0]), 64'(0));
        chk("rst_ovf", 64'(ovf_o[0]), 64'(0));
        chk("rst_in_ready", 64'(rdy[0]), 64'(0));

        // Three saturating ops held under backpressure, then reset between clock edges.
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(40'h7F_FFFF_FFFF, 1'b1, 21'h1F_FFFF, 1'b0);
        repeat (3) step();
        in_valid = 1'b0;
        chk("fill_valid", 64'(ovalid[0]), 64'(1));
        chk("fill_dout", 64'(dout_o[0]), 64'(32'h7FFF_FFFF));
        chk("fill_in_ready", 64'(rdy[0]), 64'(0));
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(ovalid[0]), 64'(0));
        chk("midrst_dout", 64'(dout_o[0]), 64'(0));
        chk("midrst_ovf", 64'(ovf_o[0]), 64'(0));
        chk("midrst_valid_n1", 64'(ovalid[2]), 64'(0));
        for (int i = 0; i < 4; i++) sbq[i].delete();
        step();
        chk("held_rst_in_ready", 64'(rdy[0]), 64'(0));

        // First accept on the first edge after release; latency per depth.
        set_op(40'h00_0800_0000, 1'b0, 21'h00_0005, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        chk("release_in_ready", 64'(rdy[0]), 64'(1));
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("lat3_e%0d", k), 64'(ovalid[0]), 64'(k == 2));
            chk($sformatf("lat1_e%0d", k), 64'(ovalid[2]), 64'(k == 0));
            chk($sformatf("lat6_e%0d", k), 64'(ovalid[3]), 64'(k == 5));
            if (k == 2) begin
                chk("lat_dout", 64'(dout_o[0]), 64'(3));
                chk("lat_dout_trunc", 64'(dout_o[1]), 64'(2));
            end
            step();
        end

        op_check("rnd_pos",   40'h00_0800_0000, 1'b0, 21'h00_0005, 1'b1, 32'h0000_0003, 32'h0000_0002, 1'b0);
        op_check("rnd_neg",   40'h00_0800_0000, 1'b0, 21'h1F_FFFB, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        op_check("sgn_uns",   40'hFF_FFFF_FFFF, 1'b0, 21'h00_0001, 1'b0, 32'h0000_1000, 32'h0000_0FFF, 1'b0);
        op_check("sgn_sgn",   40'hFF_FFFF_FFFF, 1'b1, 21'h00_0001, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        op_check("sgn_both",  40'hFF_FFFF_FFFF, 1'b1, 21'h1F_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        op_check("sat_pos",   40'h7F_FFFF_FFFF, 1'b1, 21'h1F_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        op_check("sat_neg",   40'h80_0000_0000, 1'b1, 21'h1F_FFFF, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        op_check("max_exact", 40'h7F_FFFF_FF00, 1'b1, 21'h10_0000, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        op_check("max_over",  40'h80_0000_0000, 1'b0, 21'h10_0000, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        op_check("min_exact", 40'h80_0000_0000, 1'b1, 21'h10_0000, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        op_check("min_over",  40'h80_0000_0000, 1'b1, 21'h10_0001, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        step();

        // Ten streamed ops; six-cycle stall starting at the first result.
        nacc       = 0;
        seen       = 1'b0;
        stall_left = 0;
        held       = '0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        rand_op();
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            acc = in_valid && rdy[0];
            if (stall_left > 0) chk("bp_in_ready_low", 64'(rdy[0]), 64'(0));
            step();
            if (acc) begin
                nacc++;
                if (nacc < 10) rand_op();
                else in_valid = 1'b0;
            end
            if (stall_left > 0) begin
                chk("bp_hold_dout", 64'(dout_o[0]), 64'(held));
                chk("bp_hold_valid", 64'(ovalid[0]), 64'(1));
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end else if (!seen && ovalid[0]) begin
                seen       = 1'b1;
                held       = dout_o[0];
                out_ready  = 1'b0;
                stall_left = 6;
            end
            if (nacc == 10 && sbq[0].size() == 0) break;
        end
        chk("bp_accepted", 64'(nacc), 64'(10));
        chk("bp_stall_seen", 64'(seen), 64'(1));
        chk("bp_drained", 64'(sbq[0].size()), 64'(0));

        // Random input gaps and output stalls.
        for (int cyc = 0; cyc < 80; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();

        // Fill the default pipe, then accept and release together every cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_op();
            step();
        end
        chk("full_valid", 64'(ovalid[0]), 64'(1));
        chk("full_in_ready_low", 64'(rdy[0]), 64'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("simul_in_ready", 64'(rdy[0]), 64'(1));
            chk("simul_out_valid", 64'(ovalid[0]), 64'(1));
            qs = sbq[0].size();
            step();
            chk("simul_occupancy", 64'(sbq[0].size()), 64'(qs));
            rand_op();
        end
        in_valid = 1'b0;
        repeat (12) step();

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb%0d_empty_at_end", i), 64'(sbq[i].size()), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
